spi_reg_frame: RTL and testbench

SPI-clock-domain register front end for the Mode 0 SPI peripheral path. It decodes framed register transactions directly from the SPI pins: a command byte, then write data bytes, or a turnaround byte followed by read data bytes, with address auto-increment. It owns a small configuration register file that the main-clock fabric reads as quasi-static outputs. Every committed write flips a toggle, which the main domain detects through its own 2-flop synchroniser.

---
 rtl/spi_reg_frame.sv | 153 +++++++++++++++
 tb/tb_spi_reg_frame.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_frame.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_frame
// Description : SPI-clock-domain register front end (Mode 0). Decodes a
//               command byte, then write data bytes or a turnaround byte
//               followed by read data bytes, with address auto-increment.
//               Holds a small configuration register file and a write
//               toggle for main-domain change detection.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_frame #(
   parameter int         NUM_REGS  = 16,
   parameter logic [7:0] RESET_VAL = 8'h00
) (
   input  logic                  i_SPI_CLK,
   input  logic                  i_rst,
   input  logic                  i_SPI_CS_n,
   input  logic                  i_SPI_PICO,
   output logic                  o_SPI_POCI,
   output logic                  o_SPI_POCI_oe,
   input  logic [7:0]            i_status,
   output logic [8*NUM_REGS-1:0] o_regs,
   output logic                  o_wrToggle,
   output logic                  o_addrErr
);

   localparam int         c_IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [6:0] c_NUM_REGS    = 7'(NUM_REGS);
   localparam logic [6:0] c_STATUS_ADDR = 7'h7F;

   typedef enum logic [1:0] {
      ST_CMD  = 2'd0,
      ST_TURN = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } state_t;

   state_t       state_q, state_d;
   logic [2:0]   bitcnt_q;
   logic [6:0]   rx_q;
   logic [7:0]   tx_q, tx_d;
   logic [6:0]   ptr_q, ptr_d;
   logic [7:0]   regs_q [NUM_REGS];
   logic         wr_tog_q;
   logic         addr_err_q;

   logic               w_byte_done;
   logic [7:0]         w_byte;
   logic               w_in_range;
   logic               w_is_status;
   logic [c_IDX_W-1:0] w_idx;
   logic [7:0]         w_rd_val;
   logic               w_load;
   logic               w_wr;
   logic               w_commit;
   logic               w_err_set;

   // The bit counter is held at zero while CS_n is high, so no byte can
   // complete outside a frame.
   assign w_byte_done = (bitcnt_q == 3'd7);
   assign w_byte      = {rx_q, i_SPI_PICO};
   assign w_in_range  = (ptr_q < c_NUM_REGS);
   assign w_is_status = (ptr_q == c_STATUS_ADDR);
   assign w_idx       = ptr_q[c_IDX_W-1:0];
   assign w_load      = w_byte_done && ((state_q == ST_TURN) || (state_q == ST_RD));
   assign w_wr        = w_byte_done && (state_q == ST_WR);
   assign w_commit    = w_wr && w_in_range;
   assign w_err_set   = (w_load || w_wr) && !w_in_range && !w_is_status;

   // Read value mux: register file, status byte at 0x7F, zero elsewhere.
   always_comb begin
      w_rd_val = 8'h00;
      if (w_in_range) begin
         w_rd_val = regs_q[w_idx];
      end else if (w_is_status) begin
         w_rd_val = i_status;
      end
   end

   // Next state, pointer and tx shift register.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tx_d    = {tx_q[6:0], 1'b0};
      if (w_load) begin
         tx_d = w_rd_val;
      end
      if (w_byte_done) begin
         case (state_q)
            ST_CMD: begin
               state_d = w_byte[7] ? ST_TURN : ST_WR;
               ptr_d   = w_byte[6:0];
            end
            ST_TURN: begin
               state_d = ST_RD;
               ptr_d   = ptr_q + 7'd1;
            end
            default: begin
               ptr_d = ptr_q + 7'd1;
            end
         endcase
      end
   end

   // Frame state: cleared by reset or by chip select going high.
   always_ff @(posedge i_SPI_CLK or posedge i_rst or posedge i_SPI_CS_n) begin
      if (i_rst || i_SPI_CS_n) begin
         state_q  <= ST_CMD;
         bitcnt_q <= 3'd0;
         rx_q     <= 7'd0;
         tx_q     <= 8'h00;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_q + 3'd1;
         rx_q     <= w_byte[6:0];
         tx_q     <= tx_d;
      end
   end

   // Persistent state: pointer, register file, write toggle, sticky error.
   always_ff @(posedge i_SPI_CLK or posedge i_rst) begin
      if (i_rst) begin
         ptr_q      <= 7'd0;
         wr_tog_q   <= 1'b0;
         addr_err_q <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= RESET_VAL;
         end
      end else begin
         ptr_q <= ptr_d;
         if (w_commit) begin
            regs_q[w_idx] <= w_byte;
            wr_tog_q      <= ~wr_tog_q;
         end
         if (w_err_set) begin
            addr_err_q <= 1'b1;
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_REGS; k++) begin : g_pack
         assign o_regs[8*k +: 8] = regs_q[k];
      end
   endgenerate

   assign o_SPI_POCI    = tx_q[7];
   assign o_SPI_POCI_oe = !i_SPI_CS_n;
   assign o_wrToggle    = wr_tog_q;
   assign o_addrErr     = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_frame
// Description : Self-checking bench for spi_reg_frame: directed frame table,
//               abort and mid-frame reset sequences, random frames against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_frame;

   localparam int NUM_REGS = 16;
   localparam int W        = 8 * NUM_REGS;

   logic          clk = 1'b0;
   logic          rst;
   logic          cs_n;
   logic          pico;
   logic          poci;
   logic          poci_oe;
   logic [7:0]    status;
   logic [W-1:0]  regs;
   logic          tog;
   logic          err;

   always #5 clk = ~clk;

   spi_reg_frame #(.NUM_REGS(NUM_REGS), .RESET_VAL(8'h00)) dut (
      .i_SPI_CLK     (clk),
      .i_rst         (rst),
      .i_SPI_CS_n    (cs_n),
      .i_SPI_PICO    (pico),
      .o_SPI_POCI    (poci),
      .o_SPI_POCI_oe (poci_oe),
      .i_status      (status),
      .o_regs        (regs),
      .o_wrToggle    (tog),
      .o_addrErr     (err)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: register contents, toggle and error flag.
   logic [7:0] m_regs [NUM_REGS];
   logic       m_tog;
   logic       m_err;

   typedef struct {
      logic [7:0]  cmd;
      int          n;
      logic [31:0] d;
      logic [31:0] rx;
      logic        tog;
      logic        err;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_REGS; k++) m_regs[k] = 8'h00;
      m_tog = 1'b0;
      m_err = 1'b0;
   endtask

   function automatic logic [W-1:0] m_pack();
      logic [W-1:0] v;
      for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = m_regs[k];
      return v;
   endfunction

   function automatic logic [7:0] m_read(input logic [6:0] a);
      if (int'(a) < NUM_REGS) return m_regs[int'(a)];
      if (a == 7'h7F) return status;
      m_err = 1'b1;
      return 8'h00;
   endfunction

   // Read: data byte j returns the value fetched at the end of byte j-1
   // (byte 0 is the turnaround), fetches cover addr..addr+n-1.
   // Write: data byte j targets addr+j, all addresses modulo 128.
   task automatic model_frame(input logic [7:0] cmd, input int n, input logic [31:0] d,
                              output logic [31:0] rx);
      logic [6:0] a;
      logic [7:0] prev;
      rx   = 32'h0;
      prev = 8'h00;
      for (int j = 0; j < n; j++) begin
         a = cmd[6:0] + 7'(j);
         if (cmd[7]) begin
            rx[31-8*j -: 8] = prev;
            prev = m_read(a);
         end else if (int'(a) < NUM_REGS) begin
            m_regs[int'(a)] = d[31-8*j -: 8];
            m_tog = ~m_tog;
         end else if (a != 7'h7F) begin
            m_err = 1'b1;
         end
      end
   endtask

   // Shift nb bits of b MSB-first; r collects POCI as the controller sees it.
   task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i >= 8 - nb; i--) begin
         pico = b[i];
         r[i] = poci;
         @(negedge clk);
      end
   endtask

   task automatic do_frame(input logic [7:0] cmd, input int n, input logic [31:0] d,
                           output logic [31:0] rx);
      logic [7:0] r;
      @(negedge clk);
      cs_n = 1'b0;
      #1;
      chk("oe_low_cs", W'(poci_oe), W'(1'b1));
      send_bits(cmd, 8, r);
      chk("cmd_rx", W'(r), W'(8'h00));
      rx = 32'h0;
      for (int j = 0; j < n; j++) begin
         send_bits(d[31-8*j -: 8], 8, r);
         rx[31-8*j -: 8] = r;
      end
      cs_n = 1'b1;
      pico = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_regs"}, regs, m_pack());
      chk({tag, "_tog"}, W'(tog), W'(m_tog));
      chk({tag, "_err"}, W'(err), W'(m_err));
   endtask

   initial begin
      logic [31:0] rx;
      logic [31:0] exp_rx;
      logic [7:0]  r;
      logic [7:0]  cmd;
      logic [6:0]  addr;
      int          n;
      int          sel;

      rst    = 1'b1;
      cs_n   = 1'b1;
      pico   = 1'b0;
      status = 8'h5C;
      model_reset();
      #12;
      chk("rst_regs", regs, '0);
      chk("rst_tog", W'(tog), '0);
      chk("rst_err", W'(err), '0);
      chk("rst_poci", W'(poci), '0);
      chk("oe_high_cs", W'(poci_oe), '0);
      @(negedge clk);
      rst = 1'b0;

      // cmd, n, data bytes, expected rx data bytes, expected toggle, expected error
      vecs[0] = '{8'h03, 1, 32'hA5000000, 32'h00000000, 1'b1, 1'b0};
      vecs[1] = '{8'h0E, 2, 32'h11220000, 32'h00000000, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 2, 32'h12340000, 32'h00000000, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 3, 32'h00000000, 32'h005C3400, 1'b0, 1'b0};
      vecs[4] = '{8'h83, 2, 32'h00000000, 32'h00A50000, 1'b0, 1'b0};
      vecs[5] = '{8'h8E, 4, 32'h00000000, 32'h00112200, 1'b0, 1'b1};
      vecs[6] = '{8'h10, 1, 32'h99000000, 32'h00000000, 1'b0, 1'b1};

      for (int i = 0; i < 7; i++) begin
         model_frame(vecs[i].cmd, vecs[i].n, vecs[i].d, exp_rx);
         do_frame(vecs[i].cmd, vecs[i].n, vecs[i].d, rx);
         for (int j = 0; j < vecs[i].n; j++)
            chk($sformatf("vec%0d_rx%0d", i, j), W'(rx[31-8*j -: 8]), W'(vecs[i].rx[31-8*j -: 8]));
         chk($sformatf("vec%0d_tog", i), W'(tog), W'(vecs[i].tog));
         chk($sformatf("vec%0d_err", i), W'(err), W'(vecs[i].err));
         chk($sformatf("vec%0d_regs", i), regs, m_pack());
      end
      chk("reg3_A5", W'(regs[31:24]), W'(8'hA5));
      chk("reg0_34", W'(regs[7:0]), W'(8'h34));

      // Abort: command plus 5 bits of data, then CS_n high.
      @(negedge clk);
      cs_n = 1'b0;
      send_bits(8'h05, 8, r);
      send_bits(8'hFF, 5, r);
      cs_n = 1'b1;
      @(negedge clk);
      check_state("abort");
      chk("abort_poci", W'(poci), '0);
      model_frame(8'h05, 1, 32'h3C000000, exp_rx);
      do_frame(8'h05, 1, 32'h3C000000, rx);
      check_state("after_abort");
      chk("reg5_3C", W'(regs[47:40]), W'(8'h3C));

      // Mid-frame reset during write data bit 4.
      @(negedge clk);
      cs_n = 1'b0;
      send_bits(8'h02, 8, r);
      send_bits(8'hFF, 4, r);
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_state("midrst");
      chk("midrst_poci", W'(poci), '0);
      #1 rst = 1'b0;
      @(negedge clk);
      cs_n = 1'b1;
      @(negedge clk);
      model_frame(8'h01, 2, 32'h77880000, exp_rx);
      do_frame(8'h01, 2, 32'h77880000, rx);
      check_state("post_rst");

      // Randomized frames against the reference model.
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int f = 0; f < 40; f++) begin
         status = 8'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0)      addr = 7'h7F;
         else if (sel == 1) addr = 7'($urandom_range(NUM_REGS, 126));
         else               addr = 7'($urandom_range(0, NUM_REGS - 1));
         cmd = {1'($urandom), addr};
         n   = int'($urandom_range(1, 4));
         rx  = $urandom;
         model_frame(cmd, n, rx, exp_rx);
         do_frame(cmd, n, rx, rx);
         if (cmd[7]) begin
            for (int j = 0; j < n; j++)
               chk($sformatf("rnd%0d_rx%0d", f, j), W'(rx[31-8*j -: 8]), W'(exp_rx[31-8*j -: 8]));
         end
         check_state($sformatf("rnd%0d", f));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
